// File: rtl/rgb2gray_stream_ctrl.sv
// rtl/rgb2gray_stream_ctrl.sv - frame sequencer for the combinational float RGB-to-gray datapath
// Reads one pixel, holds the operands for a settle window, then writes the result with backpressure.
module rgb2gray_stream_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 18,
  parameter int SETTLE_CYC = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   pix_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_r,
  input  logic [DATA_W-1:0] rd_g,
  input  logic [DATA_W-1:0] rd_b,
  output logic [DATA_W-1:0] dp_r,
  output logic [DATA_W-1:0] dp_g,
  output logic [DATA_W-1:0] dp_b,
  input  logic [DATA_W-1:0] dp_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_LOAD   = 3'd2,
    S_SETTLE = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT     = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [7:0]      SETTLE_INIT = 8'(SETTLE_CYC);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [7:0]          settle_q, settle_d;
  logic [DATA_W-1:0]   dpr_q, dpr_d;
  logic [DATA_W-1:0]   dpg_q, dpg_d;
  logic [DATA_W-1:0]   dpb_q, dpb_d;

  logic [ADDR_W:0]     pix_clamped;
  logic                last_pix;
  logic                abort_act;

  // Counts above the addressable range would make the index wrap; clamp them at the source.
  assign pix_clamped = (pix_count > MAX_CNT) ? MAX_CNT : pix_count;
  assign last_pix    = ({1'b0, idx_q} == (cnt_q - ONE_CNT));
  assign abort_act   = abort && (state_q != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      dpr_q    <= '0;
      dpg_q    <= '0;
      dpb_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      dpr_q    <= dpr_d;
      dpg_q    <= dpg_d;
      dpb_q    <= dpb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = (pix_clamped == '0) ? S_DONE : S_READ;
      S_READ:   state_d = S_LOAD;
      S_LOAD:   state_d = S_SETTLE;
      S_SETTLE: if (settle_q <= 8'd1) state_d = S_WRITE;
      S_WRITE:  if (out_ready) state_d = last_pix ? S_DONE : S_READ;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Abort overrides everything, including a write transfer in the same cycle.
    if (abort_act) state_d = S_IDLE;
  end

  always_comb begin
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    dpr_d    = dpr_q;
    dpg_d    = dpg_q;
    dpb_d    = dpb_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = pix_clamped;
          idx_d = '0;
        end
      end
      S_LOAD: begin
        dpr_d    = rd_r;
        dpg_d    = rd_g;
        dpb_d    = rd_b;
        settle_d = SETTLE_INIT;
      end
      S_SETTLE: settle_d = settle_q - 8'd1;
      S_WRITE: begin
        if (out_ready && !last_pix && !abort_act) idx_d = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_en   = (state_q == S_READ);
    wr_en   = (state_q == S_WRITE);
    done    = (state_q == S_DONE);
    busy    = (state_q != S_IDLE);
    rd_addr = idx_q;
    wr_addr = idx_q;
    wr_data = dp_out;
    dp_r    = dpr_q;
    dp_g    = dpg_q;
    dp_b    = dpb_q;
  end

endmodule

// File: tb/tb_rgb2gray_stream_ctrl.sv
// tb/tb_rgb2gray_stream_ctrl.sv - scoreboard bench for the RGB-to-gray frame sequencer
module tb_rgb2gray_stream_ctrl;
  localparam int DW = 32;
  localparam int AW = 18;
  localparam int SC = 6;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW:0]   pix_count = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_r = '0;
  logic [DW-1:0] rd_g = '0;
  logic [DW-1:0] rd_b = '0;
  logic [DW-1:0] dp_r, dp_g, dp_b, dp_out;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   neg_cnt = 0;
  int   base = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;
  int   pat = 0;
  int   stall_addr = -1;
  int   stall_len = 0;
  int   arm_id = 0;
  int   seen_arm = 0;
  int   stall_left = 0;

  rgb2gray_stream_ctrl #(.DATA_W(DW), .ADDR_W(AW), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pix_count(pix_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_r(rd_r), .rd_g(rd_g), .rd_b(rd_b),
    .dp_r(dp_r), .dp_g(dp_g), .dp_b(dp_b), .dp_out(dp_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic real f32_to_real(input logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] real_to_f32(input real x);
    logic [63:0] b;
    logic [10:0] e;
    logic [30:0] mag;
    logic [28:0] rem;
    b = $realtobits(x);
    if (b[62:52] == 11'd0) return {b[63], 31'd0};
    e   = b[62:52] - 11'd896;
    mag = {e[7:0], b[51:29]};
    rem = b[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && mag[0])) mag = mag + 31'd1;
    return {b[63], mag};
  endfunction

  function automatic logic [31:0] gray(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
    return real_to_f32(0.299 * f32_to_real(r) + 0.587 * f32_to_real(g) + 0.114 * f32_to_real(b));
  endfunction

  function automatic logic [31:0] pix_val(input int c, input int a);
    if (pat == 0) return 32'h3F80_0000;
    return real_to_f32(real'(((a * 7 + c * 13 + a / 3) % 200) + 1) / 128.0);
  endfunction

  assign dp_out = gray(dp_r, dp_g, dp_b);

  always @(posedge clk) begin
    if (rd_en) begin
      rd_r <= pix_val(0, int'(rd_addr));
      rd_g <= pix_val(1, int'(rd_addr));
      rd_b <= pix_val(2, int'(rd_addr));
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Writer model: drives out_ready for the next edge, then scores any transfer seen this cycle.
  always @(negedge clk) begin
    exp_t e;
    neg_cnt = neg_cnt + 1;
    if (arm_id != seen_arm) begin
      seen_arm   = arm_id;
      stall_left = stall_len;
    end
    if (wr_en && stall_left > 0 && int'(wr_addr) == stall_addr) begin
      out_ready  = 1'b0;
      stall_left = stall_left - 1;
      if (sb_q.size() > 0) begin
        chk("hold_addr", 64'(wr_addr), 64'(sb_q[0].addr));
        chk("hold_data", 64'(wr_data), 64'(sb_q[0].data));
        chk("hold_dp_r", 64'(dp_r), 64'(pix_val(0, int'(sb_q[0].addr))));
      end
    end else begin
      out_ready = 1'b1;
    end
    if (rd_en) rd_cnt = rd_cnt + 1;
    if (rd_en && wr_en) chk("rd_wr_excl", 64'(rd_en & wr_en), 64'd0);
    if (wr_en && out_ready) begin
      wr_cnt = wr_cnt + 1;
      chk("wr_expected", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = neg_cnt - base;
    end
  end

  task automatic start_frame(input int n, input int npush, input int p, input int saddr, input int slen);
    exp_t e;
    pat        = p;
    stall_addr = saddr;
    stall_len  = slen;
    arm_id     = arm_id + 1;
    for (int a = 0; a < npush; a++) begin
      e.addr = AW'(a);
      e.data = (p == 0) ? 32'h3F80_0000 : gray(pix_val(0, a), pix_val(1, a), pix_val(2, a));
      sb_q.push_back(e);
    end
    @(negedge clk);
    pix_count = (AW + 1)'(n);
    start     = 1'b1;
    @(posedge clk);
    base = neg_cnt;
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int limit);
    for (int i = 0; i < limit && done_cnt == prev; i++) @(posedge clk);
    chk("done_seen", 64'(done_cnt), 64'(prev + 1));
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  initial begin
    int d0, w0, r0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr", 64'({rd_addr, wr_addr}), 64'd0);
    chk("rst_dp", 64'(dp_r | dp_g | dp_b), 64'd0);
    rst = 1'b0;

    // single pixel of 1.0
    d0 = done_cnt; w0 = wr_cnt;
    start_frame(1, 1, 0, -1, 0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      chk($sformatf("single_busy_c%0d", c), 64'(busy), 64'(c <= 10));
      chk($sformatf("single_done_c%0d", c), 64'(done), 64'(c == 10));
    end
    @(posedge clk);
    chk("single_done_cyc", 64'(done_cyc), 64'd10);
    chk("single_writes", 64'(wr_cnt - w0), 64'd1);
    chk("single_sb_empty", 64'(sb_q.size()), 64'd0);

    // 100x100 frame
    d0 = done_cnt; w0 = wr_cnt;
    start_frame(10000, 10000, 1, -1, 0);
    wait_done(d0, 95000);
    chk("frame_done_cyc", 64'(done_cyc), 64'd90001);
    repeat (5) @(posedge clk);
    chk("frame_done_once", 64'(done_cnt - d0), 64'd1);
    chk("frame_writes", 64'(wr_cnt - w0), 64'd10000);
    chk("frame_sb_empty", 64'(sb_q.size()), 64'd0);

    // backpressure on the second write
    d0 = done_cnt; w0 = wr_cnt;
    start_frame(3, 3, 1, 1, 4);
    wait_done(d0, 200);
    chk("bp_done_cyc", 64'(done_cyc), 64'd32);
    chk("bp_writes", 64'(wr_cnt - w0), 64'd3);
    chk("bp_sb_empty", 64'(sb_q.size()), 64'd0);

    // zero-length frame
    d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt;
    start_frame(0, 0, 1, -1, 0);
    @(negedge clk);
    chk("zero_done_c1", 64'(done), 64'd1);
    chk("zero_busy_c1", 64'(busy), 64'd1);
    @(negedge clk);
    chk("zero_done_c2", 64'(done), 64'd0);
    chk("zero_busy_c2", 64'(busy), 64'd0);
    @(posedge clk);
    chk("zero_done_cyc", 64'(done_cyc), 64'd1);
    chk("zero_no_rd_wr", 64'((rd_cnt - r0) + (wr_cnt - w0)), 64'd0);
    chk("zero_done_once", 64'(done_cnt - d0), 64'd1);

    // abort in the settle window of pixel 5
    d0 = done_cnt;
    start_frame(10, 5, 1, -1, 0);
    repeat (50) @(negedge clk);
    chk("abort_addr", 64'(rd_addr), 64'd5);
    chk("abort_busy_pre", 64'(busy), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy_post", 64'(busy), 64'd0);
    @(posedge clk);
    r0 = rd_cnt; w0 = wr_cnt;
    repeat (20) @(posedge clk);
    chk("abort_quiet", 64'((rd_cnt - r0) + (wr_cnt - w0)), 64'd0);
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    chk("abort_sb_empty", 64'(sb_q.size()), 64'd0);
    start_frame(2, 2, 1, -1, 0);
    wait_done(d0, 100);
    chk("restart_done_cyc", 64'(done_cyc), 64'd19);
    chk("restart_sb_empty", 64'(sb_q.size()), 64'd0);

    // async reset while stalled in WRITE, then ignored start while busy
    start_frame(2, 2, 1, 0, 1000);
    repeat (11) @(negedge clk);
    chk("rst_mid_wr_en_pre", 64'(wr_en), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_wr_en", 64'(wr_en), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    d0 = done_cnt; w0 = wr_cnt;
    start_frame(1, 1, 1, -1, 0);
    repeat (3) @(negedge clk);
    pix_count = (AW + 1)'(5);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(d0, 100);
    chk("fresh_done_cyc", 64'(done_cyc), 64'd10);
    repeat (15) @(posedge clk);
    chk("fresh_writes", 64'(wr_cnt - w0), 64'd1);
    chk("fresh_done_once", 64'(done_cnt - d0), 64'd1);
    chk("fresh_sb_empty", 64'(sb_q.size()), 64'd0);
    chk("fresh_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/rgb2gray_stream_ctrl.md
Name: rgb2gray_stream_ctrl

Overview:
Sequencer for the combinational IEEE-754 single-precision RGB-to-gray datapath. Runs one frame per start command:
- Fetches each pixel's red, green and blue float words from three read-port image memories.
- Holds them stable on registered datapath inputs for a fixed settle window.
- Writes the datapath result to an output memory or writer, with backpressure.

It replaces the fixed-delay pixel stepping used in simulation with a synthesizable, clocked frame engine.

Parameters:
DATA_W, 32, float word width (IEEE-754 single)
ADDR_W, 18, pixel address width (covers 500*500 frame)
SETTLE_CYC, 6, clock cycles datapath inputs are held before the result is sampled; legal range 1..255

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
start  in  1  begin frame; sampled only in IDLE
abort  in  1  synchronous frame abort
pix_count  in  ADDR_W+1  pixels in frame; sampled with start
rd_en  out  1  read strobe to red/green/blue memories
rd_addr  out  ADDR_W  pixel index for reads
rd_r, rd_g, rd_b  in  DATA_W each  memory data, valid exactly 1 cycle after rd_en
dp_r, dp_g, dp_b  out  DATA_W each  registered datapath operands
dp_out  in  DATA_W  combinational datapath result
wr_en  out  1  write strobe (wr_en & out_ready = transfer)
wr_addr  out  ADDR_W  pixel index of result
wr_data  out  DATA_W  result word (dp_out)
out_ready  in  1  writer can accept
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, rst=1): state=IDLE; rd_en=0, wr_en=0, done=0, busy=0; rd_addr, wr_addr, dp_r/g/b, pixel index, settle counter and latched count all 0.
- FSM states: IDLE, READ, LOAD, SETTLE, WRITE, DONE.
- IDLE: on start=1, latch pix_count and clear index. If the latched count is 0, go to DONE; otherwise go to READ. start is ignored in all other states.
- READ (1 cycle): rd_en=1, rd_addr=index. Next state LOAD.
- LOAD (1 cycle): register rd_r/g/b into dp_r/g/b and load the settle counter with SETTLE_CYC. Next state SETTLE.
- SETTLE: the counter decrements each cycle. After exactly SETTLE_CYC cycles, go to WRITE. dp_r/g/b must not change during SETTLE or WRITE.
- WRITE: wr_en=1, wr_addr=index, wr_data=dp_out.
  - If out_ready=0, hold in WRITE; all outputs stay stable.
  - On a transfer, if index==count-1 go to DONE; otherwise increment the index and go to READ.
- DONE (1 cycle): done=1. Next state IDLE.
- Per-pixel cost with out_ready held high: SETTLE_CYC+3 cycles.
- Frame timing, with the start-sampling edge as cycle 0: done is high in cycle N*(SETTLE_CYC+3)+1. Each out_ready=0 cycle in WRITE adds 1 cycle.
- Address and count width:
  - The index wraps nowhere. The maximum count is 2^ADDR_W, and the last address is 2^ADDR_W-1.
  - pix_count values above 2^ADDR_W are clamped to 2^ADDR_W.
- abort=1 in any non-IDLE state:
  - Next state is IDLE. rd_en and wr_en are 0 from the next cycle, and no done pulse is generated.
  - abort takes priority over a same-cycle write transfer: a pending WRITE is not counted.
  - abort in IDLE has no effect. If start and abort are both high in IDLE, start wins.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values; no partial done.
- rd_en and wr_en are never high in the same cycle.

Test Plan:
- Single pixel, SETTLE_CYC=6: pix_count=1, rd_r=rd_g=rd_b=32'h3F800000 (1.0), float gray model on dp_out, out_ready=1.
  Expected: one write, wr_addr=0, wr_data=32'h3F800000; done in cycle 10; busy high for cycles 1..10.
- 100x100 frame: pix_count=10000, memories preloaded, out_ready=1.
  Expected: 10000 writes, addresses 0..9999 in order, each wr_data equals the model result; done in cycle 90001; exactly one done pulse.
- Backpressure: pix_count=3, out_ready low for 4 cycles in the second WRITE.
  Expected: wr_en/wr_addr=1/wr_data held stable for those 4 cycles; dp_r/g/b unchanged; done delayed to cycle 32.
- Zero count: pix_count=0 with start.
  Expected: no rd_en or wr_en; done in cycle 1; back to IDLE in cycle 2.
- Abort in SETTLE of pixel 5 (pix_count=10).
  Expected: no further rd_en/wr_en, no done, busy low the cycle after; a new start then runs from address 0.
- Async reset asserted mid-WRITE with out_ready=0.
  Expected: wr_en, busy and done fall immediately without a clock edge; start after reset release behaves as a fresh frame. Also check that start pulses while busy are ignored.
